// File: rtl/matchcnt_pkg.sv
// matchcnt_pkg: shared FSM state codes and default sizing for match_counter
package matchcnt_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GATE  = 2'b01,
        LATCH = 2'b10
    } state_t;
    localparam int GATE_CYCLES_DEF = 1000;
    localparam int CNT_W_DEF       = 16;
endpackage

// File: rtl/match_counter_bcd_digit.sv
// bcd_digit: one packed-BCD digit incrementer for match_counter's decimal accumulator
// ports: d digit in, inc increment request, q incremented digit, co carry to next digit, nine d==9
module bcd_digit (
    input  logic [3:0] d,
    input  logic       inc,
    output logic [3:0] q,
    output logic       co,
    output logic       nine
);
    assign nine = d == 4'd9;
    assign q    = inc ? (nine ? 4'd0 : d + 4'd1) : d;
    assign co   = inc & nine;
endmodule

// File: rtl/match_counter.sv
// match_counter: counts hit pulses over a GATE_CYCLES-long window, saturating, with BCD option MATCH_CNT_BCD_EN
// ports: clk clock, rst async active-low reset, hit match pulse, start open window, abort cancel window,
//        count/ovf last result, done result-update pulse, busy window open, statout FSM state code
module match_counter
    import matchcnt_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hit,
    input  logic             start,
    input  logic             abort,
    output logic [CNT_W-1:0] count,
    output logic             ovf,
    output logic             done,
    output logic             busy,
    output logic [1:0]       statout
);
    localparam int TW = $clog2(GATE_CYCLES);
    state_t           state;
    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] acc, acc_inc, acc_nxt;
    logic             acc_ovf, ovf_nxt, sat, wrap, last;
`ifdef MATCH_CNT_BCD_EN
    localparam int ND = CNT_W / 4;
    logic [ND:0]   carry;
    logic [ND-1:0] nine;
    assign carry[0] = 1'b1;
    for (genvar i = 0; i < ND; i++) begin : g_bcd
        bcd_digit u_digit (
            .d    (acc[4*i +: 4]),
            .inc  (carry[i]),
            .q    (acc_inc[4*i +: 4]),
            .co   (carry[i+1]),
            .nine (nine[i])
        );
    end
    // all-9s holds the value; a carry out of the top digit is what would have wrapped
    assign sat  = &nine;
    assign wrap = carry[ND];
`else
    assign acc_inc = acc + 1'b1;
    assign sat     = &acc;
    assign wrap    = sat;
`endif
    assign acc_nxt = (hit && !sat) ? acc_inc : acc;
    assign ovf_nxt = acc_ovf | (hit & wrap);
    assign last    = timer == TW'(GATE_CYCLES - 1);
    assign busy    = state == GATE;
    assign statout = state;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            timer   <= '0;
            acc     <= '0;
            acc_ovf <= 1'b0;
            count   <= '0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start && !abort) begin
                    state   <= GATE;
                    timer   <= '0;
                    acc     <= '0;
                    acc_ovf <= 1'b0;
                end
                GATE: if (abort) begin
                    state <= IDLE;
                end else begin
                    acc     <= acc_nxt;
                    acc_ovf <= ovf_nxt;
                    timer   <= timer + 1'b1;
                    // publish on the closing edge so done and the new result appear together
                    if (last) begin
                        state <= LATCH;
                        count <= acc_nxt;
                        ovf   <= ovf_nxt;
                        done  <= 1'b1;
                    end
                end
                LATCH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
